video_stream_flush_ctrl: RTL and testbench

Sequencer in front of `video_stream_to_window`. It passes the incoming pixel stream through with one register stage and measures the active line length. After each frame it injects `WIN_SIZE/2` padding lines during vertical blanking, so the window generator drains its line buffers and emits the bottom rows of the frame. Frame end is moved from the last real line to the last padding line, so downstream frame framing covers the flushed rows.

---
 rtl/video_win_pkg.sv | 14 +
 rtl/video_line_meter.sv | 46 ++++
 rtl/video_stream_flush_ctrl.sv | 162 ++++++++++++++++
 tb/tb_video_stream_flush_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_win_pkg.sv
// video_win_pkg: shared state type and sizing helpers for the video window stream blocks.
package video_win_pkg;

  typedef enum logic [1:0] {PASS, GAP, FLUSH} flush_state_t;

  function automatic int flush_lines(input int win_size);
    return win_size / 2;
  endfunction

  function automatic int word_cnt_w(input int max_line_size, input int px_per_clk);
    return $clog2(max_line_size / px_per_clk + 2);
  endfunction

endpackage

// File: rtl/video_line_meter.sv
// video_line_meter: counts valid words per line and keeps the last line's length and final valid mask.
module video_line_meter
  import video_win_pkg::*;
#(
  parameter int PX_PER_CLK    = 4,
  parameter int MAX_LINE_SIZE = 1936,
  localparam int CW           = word_cnt_w(MAX_LINE_SIZE, PX_PER_CLK)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [PX_PER_CLK-1:0] px_data_val_i,
  input  logic                  line_start_i,
  input  logic                  line_end_i,
  output logic [CW-1:0]         line_words_o,
  output logic [CW-1:0]         line_words_nxt_o,
  output logic [PX_PER_CLK-1:0] last_mask_o
);

  logic [CW-1:0]         cnt_q, cnt_d, line_words_q, line_words_d;
  logic [PX_PER_CLK-1:0] mask_q, mask_d;

  always_comb begin
    cnt_d        = ~|px_data_val_i ? cnt_q :
                   line_start_i    ? CW'(1) :
                   &cnt_q          ? cnt_q : cnt_q + 1'b1;
    line_words_d = line_end_i ? cnt_d : line_words_q;
    mask_d       = line_end_i ? px_data_val_i : mask_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      line_words_q <= '0;
      mask_q       <= '0;
    end else begin
      cnt_q        <= cnt_d;
      line_words_q <= line_words_d;
      mask_q       <= mask_d;
    end
  end

  assign line_words_o     = line_words_q;
  assign line_words_nxt_o = line_words_d;
  assign last_mask_o      = mask_q;

endmodule

// File: rtl/video_stream_flush_ctrl.sv
// video_stream_flush_ctrl: registers the pixel stream and appends WIN_SIZE/2 padding lines after
// each frame so a downstream window generator drains its line buffers.
module video_stream_flush_ctrl
  import video_win_pkg::*;
#(
  parameter int                PX_WIDTH      = 12,
  parameter int                PX_PER_CLK    = 4,
  parameter int                WIN_SIZE      = 3,
  parameter int                MAX_LINE_SIZE = 1936,
  parameter int                LINE_GAP      = 4,
  parameter logic [PX_WIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_i,
  input  logic [PX_PER_CLK-1:0]          px_data_val_i,
  input  logic                           line_start_i,
  input  logic                           line_end_i,
  input  logic                           frame_start_i,
  input  logic                           frame_end_i,
  output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
  output logic [PX_PER_CLK-1:0]          px_data_val_o,
  output logic                           line_start_o,
  output logic                           line_end_o,
  output logic                           frame_start_o,
  output logic                           frame_end_o,
  output logic                           flush_o,
  output logic                           busy_o,
  output logic                           overrun_o
);

  localparam int FL = flush_lines(WIN_SIZE);
  localparam int CW = word_cnt_w(MAX_LINE_SIZE, PX_PER_CLK);
  localparam int DW = PX_PER_CLK * PX_WIDTH;
  localparam int GW = $clog2(LINE_GAP + 2);
  localparam int LW = $clog2(FL + 2);
  localparam logic [DW-1:0] PAD_WORD = {PX_PER_CLK{PAD_VALUE}};

  flush_state_t          state_q, state_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [LW-1:0]         lines_q, lines_d;
  logic [CW-1:0]         word_q, word_d, idx;
  logic [DW-1:0]         px_q, px_d;
  logic [PX_PER_CLK-1:0] val_q, val_d;
  logic                  ls_q, ls_d, le_q, le_d, fs_q, fs_d, fe_q, fe_d;
  logic                  flush_q, flush_d, busy_q, busy_d, ovr_q, ovr_d;
  logic [CW-1:0]         line_words, line_words_nxt;
  logic [PX_PER_CLK-1:0] last_mask;
  logic                  ovr, fe_hold, emit, last, done;

  video_line_meter #(
    .PX_PER_CLK   (PX_PER_CLK),
    .MAX_LINE_SIZE(MAX_LINE_SIZE)
  ) u_meter (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .px_data_val_i   (px_data_val_i),
    .line_start_i    (line_start_i),
    .line_end_i      (line_end_i),
    .line_words_o    (line_words),
    .line_words_nxt_o(line_words_nxt),
    .last_mask_o     (last_mask)
  );

  // Frame-end decision uses the meter's next value so a line ending on the same cycle counts.
  assign fe_hold = (FL != 0) && (line_words_nxt != '0);
  assign ovr     = (state_q != PASS) && ((|px_data_val_i) || frame_start_i);
  assign emit    = (state_q == FLUSH) || (gap_q == GW'(1));
  assign idx     = (state_q == FLUSH) ? word_q : '0;
  assign last    = (idx + 1'b1) == line_words;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    lines_d = lines_q;
    word_d  = word_q;
    ovr_d   = ovr_q | ovr;
    px_d    = '0;
    val_d   = '0;
    ls_d    = 1'b0;
    le_d    = 1'b0;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    flush_d = 1'b0;
    done    = 1'b0;
    if (state_q == PASS || ovr) begin
      state_d = (frame_end_i && fe_hold) ? GAP : PASS;
      gap_d   = GW'(LINE_GAP);
      lines_d = LW'(FL);
      px_d    = px_data_i;
      val_d   = px_data_val_i;
      ls_d    = line_start_i;
      le_d    = line_end_i;
      fs_d    = frame_start_i;
      fe_d    = frame_end_i && !fe_hold;
    end else if (emit) begin
      px_d    = PAD_WORD;
      val_d   = last ? last_mask : '1;
      ls_d    = idx == '0;
      le_d    = last;
      flush_d = 1'b1;
      word_d  = idx + 1'b1;
      state_d = FLUSH;
      // The extra count gives LINE_GAP fully idle cycles after a padding line's end.
      if (last && lines_q > LW'(1)) begin
        state_d = GAP;
        gap_d   = GW'(LINE_GAP + 1);
        lines_d = lines_q - 1'b1;
      end else if (last) begin
        state_d = PASS;
        fe_d    = 1'b1;
        done    = 1'b1;
      end
    end else begin
      gap_d = gap_q - 1'b1;
    end
    busy_d = (state_d != PASS) || done;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PASS;
      gap_q   <= '0;
      lines_q <= '0;
      word_q  <= '0;
      px_q    <= '0;
      val_q   <= '0;
      ls_q    <= 1'b0;
      le_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      lines_q <= lines_d;
      word_q  <= word_d;
      px_q    <= px_d;
      val_q   <= val_d;
      ls_q    <= ls_d;
      le_q    <= le_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign px_data_o     = px_q;
  assign px_data_val_o = val_q;
  assign line_start_o  = ls_q;
  assign line_end_o    = le_q;
  assign frame_start_o = fs_q;
  assign frame_end_o   = fe_q;
  assign flush_o       = flush_q;
  assign busy_o        = busy_q;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_video_stream_flush_ctrl.sv
// tb_video_stream_flush_ctrl: three instances (WIN_SIZE 3, 5, 1) checked against a schedule-based model.
module tb_video_stream_flush_ctrl;

  localparam int G = 4;
  localparam int F_OVR = 0, F_BUSY = 1, F_FL = 2, F_FE = 3, F_FS = 4, F_LE = 5, F_LS = 6;

  logic clk = 1'b0, rst = 1'b1;
  logic [47:0] px_i = '0;
  logic [3:0]  val_i = '0;
  logic        ls_i = 1'b0, le_i = 1'b0, fs_i = 1'b0, fe_i = 1'b0;

  logic [47:0] o_px[3];
  logic [3:0]  o_val[3];
  logic        o_ls[3], o_le[3], o_fs[3], o_fe[3], o_fl[3], o_busy[3], o_ovr[3];
  logic [58:0] dv[3], exp_v[3];

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    video_stream_flush_ctrl #(
      .WIN_SIZE(g == 0 ? 3 : (g == 1 ? 5 : 1)),
      .LINE_GAP(G)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .px_data_i    (px_i),
      .px_data_val_i(val_i),
      .line_start_i (ls_i),
      .line_end_i   (le_i),
      .frame_start_i(fs_i),
      .frame_end_i  (fe_i),
      .px_data_o    (o_px[g]),
      .px_data_val_o(o_val[g]),
      .line_start_o (o_ls[g]),
      .line_end_o   (o_le[g]),
      .frame_start_o(o_fs[g]),
      .frame_end_o  (o_fe[g]),
      .flush_o      (o_fl[g]),
      .busy_o       (o_busy[g]),
      .overrun_o    (o_ovr[g])
    );
    assign dv[g] = {o_px[g], o_val[g], o_ls[g], o_le[g], o_fs[g], o_fe[g], o_fl[g], o_busy[g], o_ovr[g]};
  end

  function automatic int fls(input int i);
    return i == 0 ? 1 : (i == 1 ? 2 : 0);
  endfunction

  // Model: a flush is a schedule of padding lines laid out in absolute cycles from the frame end.
  int   cyc = 0, cur = 0, lw = 0;
  logic [3:0] lmask = '0;
  bit   mvalid = 0;
  bit   sched[3], movr[3];
  int   st[3], el[3], ln[3];
  logic [3:0] mk[3];
  int   mo, mp, mw;
  bit   mhold;

  always @(posedge clk) begin
    if (rst) begin
      cur = 0; lw = 0; lmask = '0; mvalid = 1;
      for (int i = 0; i < 3; i++) begin
        sched[i] = 0; movr[i] = 0; exp_v[i] = '0;
      end
    end else begin
      if (|val_i) cur = ls_i ? 1 : (cur < 511 ? cur + 1 : cur);
      if (le_i) begin
        lw = cur; lmask = val_i;
      end
      for (int i = 0; i < 3; i++) begin
        if (sched[i] && cyc < el[i] && ((|val_i) || fs_i)) begin
          sched[i] = 0; movr[i] = 1;
        end
        if (sched[i] && cyc + 1 <= el[i]) begin
          mo = cyc + 1 - st[i];
          mp = ln[i] + G;
          exp_v[i] = {57'd0, 1'b1, movr[i]};
          if (mo >= 0 && (mo % mp) < ln[i]) begin
            mw = mo % mp;
            exp_v[i] = {48'd0, (mw == ln[i] - 1) ? mk[i] : 4'hF, mw == 0, mw == ln[i] - 1, 1'b0,
                        (mw == ln[i] - 1) && (mo / mp == fls(i) - 1), 1'b1, 1'b1, movr[i]};
          end
        end else begin
          mhold = fls(i) > 0 && lw > 0;
          sched[i] = fe_i && mhold;
          if (sched[i]) begin
            st[i] = cyc + 1 + G; ln[i] = lw; mk[i] = lmask;
            el[i] = st[i] + (fls(i) - 1) * (lw + G) + lw - 1;
          end
          exp_v[i] = {px_i, val_i, ls_i, le_i, fs_i, fe_i && !mhold, 1'b0, sched[i], movr[i]};
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst && mvalid) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dv[i] !== exp_v[i]) begin
          errors++;
          $display("FAIL stream u%0d t=%0t got=%h want=%h", i, $time, dv[i], exp_v[i]);
        end
      end
    end
  end

  task automatic lit(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic drive(input logic [47:0] d, input logic [3:0] v, input logic ls, input logic le,
                       input logic fs, input logic fe);
    @(negedge clk);
    px_i = d; val_i = v; ls_i = ls; le_i = le; fs_i = fs; fe_i = fe;
  endtask

  task automatic idle();
    drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int nl, input int nw, input logic [3:0] lm, input int lgap);
    for (int l = 0; l < nl; l++) begin
      for (int w = 0; w < nw; w++)
        drive({$urandom, $urandom}, (w == nw - 1) ? lm : 4'hF, w == 0, w == nw - 1,
              l == 0 && w == 0, l == nl - 1 && w == nw - 1);
      if (l != nl - 1)
        repeat (lgap) idle();
    end
  endtask

  task automatic basic_scn();
    frame(3, 4, 4'hF, 2);
    for (int j = 1; j <= 18; j++) begin
      idle();
      if (j == 1) begin
        lit("basic_le_n1", dv[0][F_LE], 1);
        lit("basic_fe_n1", dv[0][F_FE], 0);
        lit("basic_busy_n1", dv[0][F_BUSY], 1);
        lit("win1_fe_n1", dv[2][F_FE], 1);
        lit("win1_busy_n1", dv[2][F_BUSY], 0);
      end
      if (j == 5) begin
        lit("basic_pad0_px", dv[0][58:11], 0);
        lit("basic_pad0_flags", dv[0][10:0], {4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      end
      if (j == 8) begin
        lit("basic_pad3_flags", dv[0][10:0], {4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        lit("win5_line1_le", dv[1][F_LE], 1);
        lit("win5_line1_no_fe", dv[1][F_FE], 0);
      end
      if (j == 9) lit("basic_busy_fall", dv[0][F_BUSY], 0);
      if (j == 12) lit("win5_gap_idle", dv[1][10:0], {4'h0, 5'b0, 1'b1, 1'b0});
      if (j == 13) lit("win5_line2_ls", dv[1][F_LS], 1);
      if (j == 16) lit("win5_line2_fe", dv[1][F_FE], 1);
      if (j == 17) lit("win5_busy_fall", dv[1][F_BUSY], 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    lit("reset_outputs_u3", dv[0], 0);
    lit("reset_outputs_u5", dv[1], 0);
    rst = 1'b0;
    repeat (2) idle();
    drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int j = 1; j <= 6; j++) begin
      idle();
      if (j == 1) begin
        lit("noline_fe_pass", dv[0][F_FE], 1);
        lit("noline_busy", dv[0][F_BUSY], 0);
      end
      if (j == 5) lit("noline_no_pad", dv[0][F_FL], 0);
    end
    basic_scn();
    frame(3, 4, 4'h3, 2);
    for (int j = 1; j <= 18; j++) begin
      idle();
      if (j == 7) lit("partial_mid_val", dv[0][10:7], 4'hF);
      if (j == 8) begin
        lit("partial_last_val", dv[0][10:7], 4'h3);
        lit("partial_last_le", dv[0][F_LE], 1);
      end
    end
    frame(3, 4, 4'hF, 2);
    for (int j = 1; j <= 18; j++) begin
      if (j == 6) drive(48'h123456789ABC, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
      else idle();
      if (j == 7) begin
        lit("ovr_word_px", dv[0][58:11], 48'h123456789ABC);
        lit("ovr_word_fs", dv[0][F_FS], 1);
        lit("ovr_flag", dv[0][F_OVR], 1);
        lit("ovr_no_flush", dv[0][F_FL], 0);
      end
      if (j == 8) lit("ovr_no_fe", dv[0][F_FE], 0);
      if (j == 18) begin
        lit("ovr_sticky", dv[0][F_OVR], 1);
        lit("win1_no_ovr", dv[2][F_OVR], 0);
      end
    end
    frame(3, 4, 4'hF, 2);
    idle();
    idle();
    #2 rst = 1'b1;
    #1 lit("rst_gap_zero_u3", dv[0], 0);
    lit("rst_gap_zero_u5", dv[1], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) idle();
    basic_scn();
    lit("rst_clears_ovr", dv[0][F_OVR], 0);
    for (int f = 0; f < 80; f++) begin
      logic [3:0] lm;
      case ($urandom_range(0, 3))
        0: lm = 4'h1;
        1: lm = 4'h3;
        2: lm = 4'h7;
        default: lm = 4'hF;
      endcase
      if ($urandom_range(0, 9) == 0) drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      else frame($urandom_range(1, 3), $urandom_range(1, 5), lm, $urandom_range(0, 2));
      repeat ($urandom_range(0, 25)) idle();
    end
    repeat (30) idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
